// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU unit.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles,
// returning the low WIDTH bits of a*b.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [CW-1:0]    cnt;

    // Only the low WIDTH bits are kept, so the multiplicand may shift out the top.
    assign sum     = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (cnt == LAST);
    assign product = sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Single-issue ALU with valid/ready in and out; MUL is iterative when
// ALU_UNIT_MUL_EN is defined, otherwise it completes at once with err=1.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and payload steady until that edge.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] rs_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             err,
    output state_t           dbg_state
);

    state_t           state, next_state;
    logic             accept, is_mul, load_alu, load_mul;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf, alu_err;
    logic             mul_busy, mul_done;
    logic [WIDTH-1:0] mul_product;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

`ifdef ALU_UNIT_MUL_EN
    logic mul_start;
    assign is_mul    = (op == OP_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (rd_data),
        .b       (rs_data),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign load_alu = accept && !is_mul;
    assign load_mul = (state == EXEC) && mul_done;

    assign add_full = {1'b0, rd_data} + {1'b0, rs_data};
    assign sub_res  = rd_data - rs_data;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
                alu_ovf   = (rd_data[WIDTH-1] == rs_data[WIDTH-1]) &&
                            (add_full[WIDTH-1] != rd_data[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_res;
                alu_carry = (rd_data < rs_data);
                alu_ovf   = (rd_data[WIDTH-1] != rs_data[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != rd_data[WIDTH-1]);
            end
            OP_AND: alu_res = rd_data & rs_data;
            OP_OR:  alu_res = rd_data | rs_data;
            OP_XOR: alu_res = rd_data ^ rs_data;
            OP_SLL: alu_res = rd_data << rs_data[SHW-1:0];
            OP_SRL: alu_res = rd_data >> rs_data[SHW-1:0];
`ifndef ALU_UNIT_MUL_EN
            OP_MUL: alu_err = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = is_mul ? EXEC : DONE;
            EXEC: begin
                // A multiplier that stops without signalling done would strand
                // the FSM; fall back to IDLE rather than hang.
                if (mul_done)      next_state = DONE;
                else if (!mul_busy) next_state = IDLE;
            end
            DONE: begin
                if (accept)         next_state = is_mul ? EXEC : DONE;
                else if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out   <= '0;
            zero  <= 1'b0;
            neg   <= 1'b0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else if (load_alu) begin
            out   <= alu_res;
            zero  <= !alu_err && (alu_res == '0);
            neg   <= alu_res[WIDTH-1];
            carry <= alu_carry;
            ovf   <= alu_ovf;
            err   <= alu_err;
        end else if (load_mul) begin
            out   <= mul_product;
            zero  <= (mul_product == '0);
            neg   <= mul_product[WIDTH-1];
            carry <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit at WIDTH=8 with a queue scoreboard and a
// separate monitor that checks result payload and arrival cycle.
module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 8;
`ifdef ALU_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = MUL_EN ? W + 1 : 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] rd_data = '0;
    logic [W-1:0] rs_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         zero, neg, carry, ovf, err;
    state_t       dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W+4:0] exp_q[$];
    int           cyc_q[$];

    alu_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd_data   (rd_data),
        .rs_data   (rs_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W+4:0] mk(input logic [W-1:0] o, input logic z, input logic n,
                                        input logic c, input logic v, input logic e);
        return {o, z, n, c, v, e};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    // driver: called just after a negedge; returns at the negedge after accept
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W+4:0] e, input int lat, input bit push);
        int n;
        in_valid = 1'b1;
        op       = o;
        rd_data  = a;
        rs_data  = b;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0, required 1 within 50 cycles");
        end else if (push) begin
            exp_q.push_back(e);
            cyc_q.push_back(cyc + lat);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin : monitor
        logic [W+4:0] e;
        int           ec;
        int           appear;
        bit           fresh;
        fresh  = 1'b1;
        appear = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                fresh = 1'b1;
            end else begin
                if (out_valid && fresh) begin
                    appear = cyc;
                    fresh  = 1'b0;
                end
                if (!out_valid) fresh = 1'b1;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got out=0x%0h, required no result", out);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = cyc_q.pop_front();
                        check("result", 32'({out, zero, neg, carry, ovf, err}), 32'(e));
                        check("latency", 32'(appear), 32'(ec));
                    end
                    fresh = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_flags", 32'({zero, neg, carry, ovf, err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // back-to-back arithmetic and logic ops, one per cycle
        issue(OP_ADD, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0, 0), 1, 1);
        issue(OP_SUB, 8'h03, 8'h02, mk(8'h01, 0, 0, 0, 0, 0), 1, 1);
        issue(OP_SUB, 8'h00, 8'h01, mk(8'hFF, 0, 1, 1, 0, 0), 1, 1);
        issue(OP_ADD, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0, 1, 0), 1, 1);
        issue(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 0, 1, 0, 0), 1, 1);
        issue(OP_SUB, 8'h80, 8'h01, mk(8'h7F, 0, 0, 0, 1, 0), 1, 1);
        issue(OP_AND, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0, 0), 1, 1);
        issue(OP_OR,  8'hF0, 8'h0F, mk(8'hFF, 0, 1, 0, 0, 0), 1, 1);
        issue(OP_XOR, 8'hAA, 8'hFF, mk(8'h55, 0, 0, 0, 0, 0), 1, 1);
        issue(OP_XOR, 8'h5A, 8'h5A, mk(8'h00, 1, 0, 0, 0, 0), 1, 1);
        issue(OP_SRL, 8'h80, 8'h07, mk(8'h01, 0, 0, 0, 0, 0), 1, 1);
        issue(OP_SLL, 8'h01, 8'h0F, mk(8'h80, 0, 1, 0, 0, 0), 1, 1);

        // multiply
        if (MUL_EN) begin
            issue(OP_MUL, 8'h0F, 8'h11, mk(8'hFF, 0, 1, 0, 0, 0), MUL_LAT, 1);
            for (int i = 0; i < W; i++) begin
                check("exec_in_ready", 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            issue(OP_MUL, 8'hFF, 8'hFF, mk(8'h01, 0, 0, 0, 0, 0), MUL_LAT, 1);
            issue(OP_MUL, 8'h10, 8'h10, mk(8'h00, 1, 0, 0, 0, 0), MUL_LAT, 1);
        end else begin
            issue(OP_MUL, 8'h0F, 8'h11, mk(8'h00, 0, 0, 0, 0, 1), MUL_LAT, 1);
            issue(OP_ADD, 8'h02, 8'h03, mk(8'h05, 0, 0, 0, 0, 0), 1, 1);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end

        // backpressure: result held, then release together with a new request
        out_ready = 1'b0;
        issue(OP_SLL, 8'h81, 8'h01, mk(8'h02, 0, 0, 0, 0, 0), 1, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out", 32'(out), 32'h02);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        issue(OP_XOR, 8'h0F, 8'hF0, mk(8'hFF, 0, 1, 0, 0, 0), 1, 1);
        repeat (2) @(negedge clk);

        // reset in the middle of an operation discards it
        if (MUL_EN) begin
            issue(OP_MUL, 8'h0F, 8'h11, '0, MUL_LAT, 0);
        end else begin
            out_ready = 1'b0;
            issue(OP_ADD, 8'h01, 8'h02, '0, 1, 0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_flags", 32'({zero, neg, carry, ovf, err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            check("midrst_no_result", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        // post-reset operation
        issue(OP_ADD, 8'h05, 8'hFB, mk(8'h00, 1, 0, 1, 0, 0), 1, 1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
